light_arb: RTL and testbench
============================

# light_arb

Round-robin scheduler that shares the 8-LED bank between three pattern requesters. Each requester asks for the bank with a level `req`. The winner drives `light` for a fixed number of step ticks, then the bank blanks for one tick before the next arbitration. The block owns the step-rate prescaler: it generates the slow/fast tick and hands the granted requester a one-cycle `step` pulse, which the requester uses to advance its pattern.

## Interface
- `DIV_SLOW`, default 50000: prescaler period in clocks for slow rate (0.5 s at 100 kHz).
- `DIV_FAST`, default 5000: prescaler period in clocks for fast rate.
- `HOLD_TICKS`, default 16: ticks a grant lasts before forced release. Must be ≥1.
- `clk100khz`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  request per requester, level-sensitive; bit i = requester i.
- `pat0`, `pat1`, `pat2`  in  8 each  pattern offered by requester i.
- `fast`  in  1  1 = use `DIV_FAST`, 0 = use `DIV_SLOW`.
- `gnt`  out  3  one-hot grant, registered.
- `step`  out  1  one-cycle pulse to the granted requester, once per tick.
- `light`  out  8  LED bank, registered.

## Operation
- Prescaler: free-running 17-bit counter `cnt`.
  - If `cnt >= DIV-1` (DIV chosen by current `fast`): `cnt <= 0` and `tick <= 1`.
  - Otherwise `cnt <= cnt+1` and `tick <= 0`.
  - The `>=` compare means switching slow→fast mid-period ticks on the next cycle; the counter never overruns.
  - The prescaler is not affected by grants.
- Pointer `last` (2 bits) holds the most recent winner. Search order is `last+1`, `last+2`, `last` (mod 3).
- FSM states: IDLE, GRANT, GAP.
  - **IDLE:** `gnt=0`, `light=0`. If any `req` bit is set: load the winner, set `last` to it, `gnt <= onehot(winner)`, `hold <= 0`, go to GRANT. No tick is needed to leave IDLE.
  - **GRANT:** every cycle `light <= pat[winner]`.
    - On `tick`: `step` = 1 and `hold <= hold+1`.
    - If `tick` and `hold == HOLD_TICKS-1`: go to GAP.
    - If `req[winner]` = 0: go to GAP immediately, regardless of tick. Release has priority over the same-cycle tick count.
  - **GAP:** `gnt <= 0`, `light <= 0`, `step` = 0. On the next `tick`, go to IDLE.
- `step = tick & (state == GRANT)`. It is combinational from registers and is high during GRANT only.
- Requests from other requesters during GRANT or GAP are ignored until IDLE.

## Timing
- Reset values: `light=0`, `gnt=0`, `step=0`, `cnt=0`, `tick=0`, `hold=0`, state IDLE, `last=2` (so requester 0 has first priority after reset).
- Arbitration latency: `req` seen in IDLE at cycle t → `gnt` valid at t+1 → `light` shows the pattern at t+2 (one register stage after the grant).
- `light` lags `pat[winner]` by one cycle throughout GRANT.
- Grant length: exactly `HOLD_TICKS` step pulses. The last pulse coincides with the transition to GAP, and `gnt` drops the cycle after it.
- GAP length: from entry until the next tick, between 1 and DIV cycles.
- Early release: `req[winner]` low at cycle t → `gnt=0` and `light=0` at t+1. No further step pulse occurs after t.
- `hold` width: ≥ clog2(`HOLD_TICKS`)+1; it is not used outside GRANT.
- Reset asserted mid-grant: all outputs go to reset values asynchronously; the next grant starts again from requester 0's priority.
- `fast` toggling mid-grant: changes only the tick spacing; the hold count is preserved.

## Test plan
Unless stated, use `DIV_SLOW=8`, `DIV_FAST=2`, `HOLD_TICKS=4`, `fast=0`.
- **Reset:** pulse `rst_n` low mid-GRANT → `light=8'h00`, `gnt=3'b000`, `step=0` immediately. After release, `req=3'b111` → `gnt=3'b001` first.
- **Round-robin:** hold `req=3'b111` with `pat0=8'h81`, `pat1=8'h42`, `pat2=8'h24` → grant order 001, 010, 100, 001. Each grant gives 4 step pulses, 8 clocks apart. `light` shows 81/42/24 with a 00 gap between grants.
- **Early release:** `req=3'b010`, drop `req[1]` after 2 steps → `gnt=0` and `light=00` next cycle, exactly 2 step pulses total, then IDLE.
- **Rate switch:** set `fast=1` when `cnt=5` → tick on the next cycle, then every 2 clocks. A grant still totals 4 steps.
- **Single requester:** `req=3'b100` steady → repeated grants to requester 2. Each grant is separated by a 1-tick blank gap, and `last` wrapping causes no starvation.
- **Idle:** `req=0` for 100 cycles → `gnt=0`, `light=0`, `step=0` throughout, while the prescaler keeps ticking.

Source files
------------

// File: rtl/light_arb.sv
// Round-robin arbiter sharing an 8-LED bank between three requesters, with built-in step prescaler.
// Latency: gnt 1 cycle after req in IDLE, light 1 cycle after gnt; no backpressure, winner advances on step.
module light_arb #(
  parameter int DIV_SLOW   = 50000,
  parameter int DIV_FAST   = 5000,
  parameter int HOLD_TICKS = 16
) (
  input  logic       clk100khz,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  input  logic       fast,
  output logic [2:0] gnt,
  output logic       step,
  output logic [7:0] light
);

  localparam int HW = $clog2(HOLD_TICKS) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q, state_d;
  logic [16:0]     cnt_q, cnt_d, div_m1;
  logic            tick_q, tick_d;
  logic [1:0]      last_q, last_d, winner, cand1, cand2;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [7:0]      light_q, light_d, pat_win;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Prescaler: >= compare lets a slow->fast switch tick immediately instead of overrunning
  always_comb begin
    div_m1 = fast ? 17'(DIV_FAST - 1) : 17'(DIV_SLOW - 1);
    if (cnt_q >= div_m1) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 17'd1;
      tick_d = 1'b0;
    end
  end

  always_comb begin
    cand1  = inc3(last_q);
    cand2  = inc3(cand1);
    if (req[cand1])      winner = cand1;
    else if (req[cand2]) winner = cand2;
    else                 winner = last_q;
    case (last_q)
      2'd0:    pat_win = pat0;
      2'd1:    pat_win = pat1;
      default: pat_win = pat2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    light_d = light_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        light_d = '0;
        if (|req) begin
          last_d  = winner;
          gnt_d   = 3'b001 << winner;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        light_d = pat_win;
        if (tick_q) hold_d = hold_q + HW'(1);
        // Release wins over a same-cycle final tick; both exits drop gnt/light together
        if (!req[last_q] || (tick_q && hold_q == HW'(HOLD_TICKS - 1))) begin
          state_d = GAP;
          gnt_d   = '0;
          light_d = '0;
        end
      end
      GAP: begin
        gnt_d   = '0;
        light_d = '0;
        if (tick_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      last_q  <= 2'd2;
      hold_q  <= '0;
      gnt_q   <= '0;
      light_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      light_q <= light_d;
    end
  end

  assign gnt   = gnt_q;
  assign light = light_q;
  assign step  = tick_q & (state_q == GRANT);

endmodule

// File: tb/tb_light_arb.sv
// Self-checking bench for light_arb: grant table plus reset, early-release, rate-switch and idle sequences.
module tb_light_arb;
  localparam int DS = 8;
  localparam int DF = 2;
  localparam int HT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [7:0] pat0 = 8'h81;
  logic [7:0] pat1 = 8'h42;
  logic [7:0] pat2 = 8'h24;
  logic       fast = 1'b0;
  logic [2:0] gnt;
  logic       step;
  logic [7:0] light;

  always #5 clk = ~clk;

  light_arb #(.DIV_SLOW(DS), .DIV_FAST(DF), .HOLD_TICKS(HT)) dut (
    .clk100khz(clk), .rst_n(rst_n), .req(req), .pat0(pat0), .pat1(pat1), .pat2(pat2),
    .fast(fast), .gnt(gnt), .step(step), .light(light)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] gnt;
    logic [7:0] light;
    int         steps;
    int         spacing;
  } exp_t;
  exp_t sb_q[$];

  // Grant monitor: collects one record per grant and scores it against the queue on release
  int         cyc = 0;
  int         grants_done = 0;
  logic       in_g = 1'b0;
  int         gidx, nsteps, last_step, sp_min, sp_max;
  logic [2:0] cap_gnt;
  logic [7:0] cap_light, first_light;
  logic       light_bad, gnt_bad;
  exp_t       e;

  always @(negedge clk) begin
    cyc++;
    check("step_only_in_grant", {31'd0, step & (gnt == 3'b000)}, 32'd0);
    if (gnt != 3'b000) begin
      if (!in_g) begin
        in_g = 1'b1; gidx = 0; nsteps = 0; cap_gnt = gnt; first_light = light;
        cap_light = 8'h00; light_bad = 1'b0; gnt_bad = 1'b0; sp_min = 1 << 20; sp_max = 0;
      end else begin
        gidx++;
        if (gnt != cap_gnt) gnt_bad = 1'b1;
        if (gidx == 1) cap_light = light;
        else if (light != cap_light) light_bad = 1'b1;
      end
      if (step) begin
        if (nsteps > 0) begin
          if (cyc - last_step < sp_min) sp_min = cyc - last_step;
          if (cyc - last_step > sp_max) sp_max = cyc - last_step;
        end
        nsteps++;
        last_step = cyc;
      end
    end else if (in_g) begin
      in_g = 1'b0;
      grants_done++;
      if (sb_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_grant: got gnt %b, none expected", cap_gnt);
      end else begin
        e = sb_q.pop_front();
        check("grant_onehot", {29'd0, cap_gnt}, {29'd0, e.gnt});
        check("grant_stable", {31'd0, gnt_bad}, 32'd0);
        check("light_first_cycle_blank", {24'd0, first_light}, 32'd0);
        check("light_pattern", {24'd0, cap_light}, {24'd0, e.light});
        check("light_stable", {31'd0, light_bad}, 32'd0);
        check("step_count", nsteps, e.steps);
        check("light_blank_after", {24'd0, light}, 32'd0);
        if (e.spacing != 0) begin
          check("step_spacing_min", sp_min, e.spacing);
          check("step_spacing_max", sp_max, e.spacing);
        end
      end
    end
  end

  task automatic wait_grants(input int target, input string name);
    int n = 0;
    while (grants_done < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, grants_done >= target}, 32'd1);
  endtask

  task automatic wait_step(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 100);
    check(name, {31'd0, step}, 32'd1);
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [7:0] light;
  } vec_t;
  vec_t tab[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

  initial begin
    int ticks, extra, n;
    tab[0] = '{3'b111, 3'b001, 8'h81};
    tab[1] = '{3'b111, 3'b010, 8'h42};
    tab[2] = '{3'b111, 3'b100, 8'h24};
    tab[3] = '{3'b111, 3'b001, 8'h81};
    tab[4] = '{3'b100, 3'b100, 8'h24};
    tab[5] = '{3'b100, 3'b100, 8'h24};
    tab[6] = '{3'b010, 3'b010, 8'h42};
    tab[7] = '{3'b011, 3'b001, 8'h81};
    tab[8] = '{3'b011, 3'b010, 8'h42};

    repeat (3) @(negedge clk);
    check("reset_gnt", {29'd0, gnt}, 32'd0);
    check("reset_light", {24'd0, light}, 32'd0);
    check("reset_step", {31'd0, step}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin, single requester with pointer wrap, and mixed request sets
    for (int i = 0; i < 9; i++) begin
      req = tab[i].req;
      sb_q.push_back('{tab[i].gnt, tab[i].light, HT, DS});
      wait_grants(i + 1, "table_grant_done");
    end
    req = 3'b000;

    // Idle: no grant activity while the prescaler keeps running
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      check("idle_gnt", {29'd0, gnt}, 32'd0);
      check("idle_light", {24'd0, light}, 32'd0);
      ticks += int'(dut.tick_q);
    end
    check("idle_prescaler_ticks", {31'd0, ticks >= 12 && ticks <= 13}, 32'd1);
    check("idle_no_grants", grants_done, 9);

    // Early release after two steps
    @(posedge clk); #1;
    req = 3'b010;
    sb_q.push_back('{3'b010, 8'h42, 2, DS});
    n = 0;
    for (int s = 0; s < 2; s++) begin
      wait_step("er_step_seen");
      n++;
    end
    @(posedge clk); #1;
    req = 3'b000;
    @(negedge clk);
    check("er_gnt_at_release", {29'd0, gnt}, 32'b010);
    @(negedge clk);
    check("er_gnt_dropped", {29'd0, gnt}, 32'd0);
    check("er_light_dropped", {24'd0, light}, 32'd0);
    wait_grants(10, "er_grant_done");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(step);
    end
    check("er_no_extra_steps", extra, 0);

    // Rate switch mid-grant at cnt==5
    @(posedge clk); #1;
    req = 3'b001;
    sb_q.push_back('{3'b001, 8'h81, HT, 0});
    wait_step("rs_first_step");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut.cnt_q != 17'd5 && n < 20);
    check("rs_cnt_reached_5", {15'd0, dut.cnt_q}, 32'd5);
    fast = 1'b1;
    @(negedge clk);
    check("rs_tick_next_cycle", {31'd0, step}, 32'd1);
    @(negedge clk);
    check("rs_no_step_between", {31'd0, step}, 32'd0);
    @(negedge clk);
    check("rs_step_2_later", {31'd0, step}, 32'd1);
    wait_grants(11, "rs_grant_done");
    req = 3'b000;
    fast = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-grant, then priority restarts at requester 0
    @(posedge clk); #1;
    req = 3'b111;
    sb_q.push_back('{3'b010, 8'h42, 1, 0});
    wait_step("rst_first_step");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_gnt", {29'd0, gnt}, 32'd0);
    check("rst_async_light", {24'd0, light}, 32'd0);
    check("rst_async_step", {31'd0, step}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    sb_q.push_back('{3'b001, 8'h81, HT, DS});
    rst_n = 1'b1;
    wait_grants(13, "rst_regrant_done");
    req = 3'b000;
    repeat (20) @(negedge clk);

    check("scoreboard_empty", sb_q.size(), 0);
    check("total_grants", grants_done, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
